servant_ram_arbiter: RTL and testbench
======================================

SERVANT_RAM_ARBITER -- requirements
Module: servant_ram_arbiter

Interface
REQ-001 Parameter aw, default 12, Wishbone byte-address width of the shared RAM; word address is [aw-1:2].
REQ-002 i_wb_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_wb_rst  in  1  synchronous, active-high reset.
REQ-004 i_ibus_adr  in  aw-2  instruction master word address ([aw-1:2]).
REQ-005 i_ibus_cyc  in  1  instruction master request (read-only master).
REQ-006 o_ibus_rdt  out  32  instruction read data.
REQ-007 o_ibus_ack  out  1  instruction transfer complete.
REQ-008 i_dbus_adr  in  aw-2  data master word address.
REQ-009 i_dbus_dat  in  32  data master write data.
REQ-010 i_dbus_sel  in  4  data master byte lanes.
REQ-011 i_dbus_we  in  1  data master write enable.
REQ-012 i_dbus_cyc  in  1  data master request.
REQ-013 o_dbus_rdt  out  32  data read data.
REQ-014 o_dbus_ack  out  1  data transfer complete.
REQ-015 o_ram_adr, o_ram_dat, o_ram_sel, o_ram_we, o_ram_cyc  out  aw-2/32/4/1/1  shared RAM port.
REQ-016 i_ram_rdt  in  32; i_ram_ack  in  1  RAM response; RAM acks one cycle after it samples cyc.

Function
REQ-017 FSM states IDLE, GNT_I, GNT_D; state is registered.
REQ-018 IDLE: o_ram_cyc=0, both master acks=0; any i_ram_ack is discarded.
REQ-019 IDLE -> GNT_D when only i_dbus_cyc=1; IDLE -> GNT_I when only i_ibus_cyc=1; both high: resolved per REQ-031/032.
REQ-020 In GNT_x, RAM port driven from master x: adr, dat, sel, we, and o_ram_cyc = x's cyc; ibus drives we=0, sel=4'hF, dat=0.
REQ-021 o_x_ack = i_ram_ack while in GNT_x and x's cyc=1; else 0; other master's ack is always 0.
REQ-022 o_ibus_rdt and o_dbus_rdt both equal i_ram_rdt at all times (no muxing).
REQ-023 GNT_x -> IDLE in the cycle after o_x_ack=1; grant is held until then regardless of the other master's requests.
REQ-024 Abort: granted master drops cyc before ack -> o_ram_cyc=0 the same cycle, any ack that cycle suppressed, state -> IDLE next cycle.
REQ-025 Latency: request seen in IDLE at cycle N -> o_ram_cyc at N+1 -> o_x_ack at N+2 -> IDLE at N+3; back-to-back requests from one master issue every 3 cycles.
REQ-026 Ungranted master's request is held pending (no ack, no RAM activity) until arbitration in IDLE.
REQ-027 Read-data validity: rdt is valid only in the cycle o_x_ack=1.

Reset
REQ-028 i_wb_rst=1 at a clock edge -> state=IDLE, last-grant register=GNT_D; takes priority over all transitions.
REQ-029 After reset, all outputs are combinational from IDLE state: o_ram_cyc=0, o_ibus_ack=0, o_dbus_ack=0, o_ram_we=0, o_ram_sel=0, o_ram_adr=0, o_ram_dat=0.
REQ-030 Reset mid-grant abandons the transfer; an in-flight i_ram_ack is discarded in IDLE, never forwarded.

Configuration
REQ-031 Macro SERVANT_ARB_RR_EN undefined: fixed priority, dbus wins simultaneous requests; no last-grant register.
REQ-032 SERVANT_ARB_RR_EN defined: round-robin; simultaneous requests granted to the master not last granted; last-grant register updated on each IDLE->GNT_x transition; first contention after reset goes to ibus.

Verification
REQ-033 Single ibus read, adr=0x010, RAM returns 0xDEADBEEF -> o_ram_cyc at N+1, o_ibus_ack=1 with rdt 0xDEADBEEF at N+2, o_dbus_ack=0 throughout.
REQ-034 dbus write adr=0x020, dat=0x12345678, sel=4'b0101 -> RAM sees exactly those values with we=1 during GNT_D; single o_dbus_ack pulse.
REQ-035 Both request continuously for 4 transfers -> fixed build: grants D,D,D,D (ibus starved); RR build: I,D,I,D.
REQ-036 dbus request arrives while GNT_I mid-transfer -> no dbus ack until ibus ack done; dbus granted at following IDLE.
REQ-037 ibus drops cyc in cycle after grant -> no o_ibus_ack; late i_ram_ack suppressed; IDLE next cycle; subsequent dbus transfer completes normally.
REQ-038 Assert i_wb_rst during GNT_D with ack pending -> IDLE next cycle, no acks emitted, RR first contention then grants ibus.

Source files
------------

// File: rtl/servant_ram_arbiter_if.sv
// Bus bundle for servant_ram_arbiter: instruction master, data master and shared RAM port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface servant_ram_arbiter_if #(
    parameter int unsigned aw = 12
);
    logic [aw-1:2] i_ibus_adr;
    logic          i_ibus_cyc;
    logic [31:0]   o_ibus_rdt;
    logic          o_ibus_ack;

    logic [aw-1:2] i_dbus_adr;
    logic [31:0]   i_dbus_dat;
    logic [3:0]    i_dbus_sel;
    logic          i_dbus_we;
    logic          i_dbus_cyc;
    logic [31:0]   o_dbus_rdt;
    logic          o_dbus_ack;

    logic [aw-1:2] o_ram_adr;
    logic [31:0]   o_ram_dat;
    logic [3:0]    o_ram_sel;
    logic          o_ram_we;
    logic          o_ram_cyc;
    logic [31:0]   i_ram_rdt;
    logic          i_ram_ack;

    modport slave (
        input  i_ibus_adr, i_ibus_cyc,
        output o_ibus_rdt, o_ibus_ack,
        input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        output o_dbus_rdt, o_dbus_ack,
        output o_ram_adr, o_ram_dat, o_ram_sel, o_ram_we, o_ram_cyc,
        input  i_ram_rdt, i_ram_ack
    );

    modport master (
        output i_ibus_adr, i_ibus_cyc,
        input  o_ibus_rdt, o_ibus_ack,
        output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        input  o_dbus_rdt, o_dbus_ack,
        input  o_ram_adr, o_ram_dat, o_ram_sel, o_ram_we, o_ram_cyc,
        output i_ram_rdt, i_ram_ack
    );
endinterface

// File: rtl/servant_ram_arbiter.sv
// Two-master (ibus/dbus) arbiter in front of a single Wishbone RAM port.
// Define SERVANT_ARB_RR_EN for round-robin on contention; default is dbus fixed priority.
module servant_ram_arbiter #(
    parameter int unsigned aw = 12
) (
    input logic                  i_wb_clk,
    input logic                  i_wb_rst,
    servant_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

    state_e state_q, state_d;
`ifdef SERVANT_ARB_RR_EN
    state_e last_gnt_q, last_gnt_d;
`endif

    logic ibus_ack;
    logic dbus_ack;

    // Acks are only forwarded to the master that currently owns the RAM and is still asking.
    assign ibus_ack = (state_q == StGntI) && bus.i_ibus_cyc && bus.i_ram_ack;
    assign dbus_ack = (state_q == StGntD) && bus.i_dbus_cyc && bus.i_ram_ack;

    always_comb begin
        state_d = state_q;
`ifdef SERVANT_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.i_ibus_cyc && bus.i_dbus_cyc) begin
`ifdef SERVANT_ARB_RR_EN
                    state_d = (last_gnt_q == StGntI) ? StGntD : StGntI;
`else
                    state_d = StGntD;
`endif
                end else if (bus.i_dbus_cyc) begin
                    state_d = StGntD;
                end else if (bus.i_ibus_cyc) begin
                    state_d = StGntI;
                end
`ifdef SERVANT_ARB_RR_EN
                if (state_d != StIdle) begin
                    last_gnt_d = state_d;
                end
`endif
            end
            // Leave on completion or when the owner abandons its cycle.
            StGntI: if (!bus.i_ibus_cyc || ibus_ack) state_d = StIdle;
            StGntD: if (!bus.i_dbus_cyc || dbus_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q <= StIdle;
`ifdef SERVANT_ARB_RR_EN
            last_gnt_q <= StGntD;
`endif
        end else begin
            state_q <= state_d;
`ifdef SERVANT_ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    always_comb begin
        bus.o_ram_adr = {(aw-2){1'b0}};
        bus.o_ram_dat = 32'h0;
        bus.o_ram_sel = 4'h0;
        bus.o_ram_we  = 1'b0;
        bus.o_ram_cyc = 1'b0;
        unique case (state_q)
            StGntI: begin
                bus.o_ram_adr = bus.i_ibus_adr;
                bus.o_ram_sel = 4'hF;
                bus.o_ram_cyc = bus.i_ibus_cyc;
            end
            StGntD: begin
                bus.o_ram_adr = bus.i_dbus_adr;
                bus.o_ram_dat = bus.i_dbus_dat;
                bus.o_ram_sel = bus.i_dbus_sel;
                bus.o_ram_we  = bus.i_dbus_we;
                bus.o_ram_cyc = bus.i_dbus_cyc;
            end
            default: ;
        endcase
    end

    assign bus.o_ibus_ack = ibus_ack;
    assign bus.o_dbus_ack = dbus_ack;
    assign bus.o_ibus_rdt = bus.i_ram_rdt;
    assign bus.o_dbus_rdt = bus.i_ram_rdt;

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Directed bench for servant_ram_arbiter with a one-cycle-ack RAM model.
// Expectations follow SERVANT_ARB_RR_EN when it is defined for the build.
module tb_servant_ram_arbiter;

    localparam int unsigned Aw = 12;
`ifdef SERVANT_ARB_RR_EN
    localparam bit RrBuild = 1'b1;
`else
    localparam bit RrBuild = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    servant_ram_arbiter_if #(.aw(Aw)) bus ();

    servant_ram_arbiter #(.aw(Aw)) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: acks one cycle after it samples cyc, never twice in a row.
    logic [31:0] mem [0:1023];
    logic        ram_ack = 1'b0;
    logic [31:0] ram_rdt = 32'h0;
    logic        preload = 1'b1;

    assign bus.i_ram_ack = ram_ack;
    assign bus.i_ram_rdt = ram_rdt;

    always @(posedge clk) begin
        if (preload) begin
            mem[10'h010] <= 32'hDEADBEEF;
            mem[10'h020] <= 32'hAAAAAAAA;
            mem[10'h030] <= 32'h00000000;
            ram_ack      <= 1'b0;
        end else if (bus.o_ram_cyc && !ram_ack) begin
            ram_ack <= 1'b1;
            ram_rdt <= mem[bus.o_ram_adr];
            if (bus.o_ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.o_ram_sel[b]) mem[bus.o_ram_adr][8*b +: 8] <= bus.o_ram_dat[8*b +: 8];
                end
            end
        end else begin
            ram_ack <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic exp_i;

    initial begin
        rst = 1'b1;
        bus.i_ibus_adr = '0;
        bus.i_ibus_cyc = 1'b0;
        bus.i_dbus_adr = 10'h3FF;
        bus.i_dbus_dat = 32'hFFFFFFFF;
        bus.i_dbus_sel = 4'hF;
        bus.i_dbus_we  = 1'b1;
        bus.i_dbus_cyc = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        preload = 1'b0;
        #1;
        // Idle must mask the (non-zero) dbus fields from the RAM port
        check("rst_ram_cyc", 32'(bus.o_ram_cyc), 32'd0);
        check("rst_ibus_ack", 32'(bus.o_ibus_ack), 32'd0);
        check("rst_dbus_ack", 32'(bus.o_dbus_ack), 32'd0);
        check("rst_ram_we", 32'(bus.o_ram_we), 32'd0);
        check("rst_ram_sel", 32'(bus.o_ram_sel), 32'd0);
        check("rst_ram_adr", 32'(bus.o_ram_adr), 32'd0);
        check("rst_ram_dat", bus.o_ram_dat, 32'd0);
        bus.i_dbus_we = 1'b0;

        // Single ibus read
        bus.i_ibus_adr = 10'h010;
        bus.i_ibus_cyc = 1'b1;
        #1 check("ird_n0_cyc", 32'(bus.o_ram_cyc), 32'd0);
        tick();
        #1;
        check("ird_n1_cyc", 32'(bus.o_ram_cyc), 32'd1);
        check("ird_n1_adr", 32'(bus.o_ram_adr), 32'h010);
        check("ird_n1_we", 32'(bus.o_ram_we), 32'd0);
        check("ird_n1_sel", 32'(bus.o_ram_sel), 32'hF);
        check("ird_n1_dat", bus.o_ram_dat, 32'h0);
        check("ird_n1_ack", 32'(bus.o_ibus_ack), 32'd0);
        tick();
        #1;
        check("ird_n2_ack", 32'(bus.o_ibus_ack), 32'd1);
        check("ird_n2_rdt", bus.o_ibus_rdt, 32'hDEADBEEF);
        check("ird_n2_dack", 32'(bus.o_dbus_ack), 32'd0);
        tick();
        #1;
        check("ird_n3_cyc", 32'(bus.o_ram_cyc), 32'd0);
        check("ird_n3_ack", 32'(bus.o_ibus_ack), 32'd0);
        bus.i_ibus_cyc = 1'b0;

        // dbus byte-lane write
        tick();
        bus.i_dbus_adr = 10'h020;
        bus.i_dbus_dat = 32'h12345678;
        bus.i_dbus_sel = 4'b0101;
        bus.i_dbus_we  = 1'b1;
        bus.i_dbus_cyc = 1'b1;
        #1 check("dwr_n0_cyc", 32'(bus.o_ram_cyc), 32'd0);
        tick();
        #1;
        check("dwr_n1_cyc", 32'(bus.o_ram_cyc), 32'd1);
        check("dwr_n1_adr", 32'(bus.o_ram_adr), 32'h020);
        check("dwr_n1_dat", bus.o_ram_dat, 32'h12345678);
        check("dwr_n1_sel", 32'(bus.o_ram_sel), 32'h5);
        check("dwr_n1_we", 32'(bus.o_ram_we), 32'd1);
        check("dwr_n1_ack", 32'(bus.o_dbus_ack), 32'd0);
        tick();
        #1;
        check("dwr_n2_ack", 32'(bus.o_dbus_ack), 32'd1);
        check("dwr_n2_iack", 32'(bus.o_ibus_ack), 32'd0);
        check("dwr_n2_irdt", bus.o_ibus_rdt, 32'hAAAAAAAA);
        tick();
        #1;
        check("dwr_n3_cyc", 32'(bus.o_ram_cyc), 32'd0);
        check("dwr_n3_ack", 32'(bus.o_dbus_ack), 32'd0);
        check("dwr_mem", mem[10'h020], 32'hAA34AA78);
        bus.i_dbus_cyc = 1'b0;
        bus.i_dbus_we  = 1'b0;

        // Continuous contention: four transfers in twelve cycles
        tick();
        bus.i_ibus_adr = 10'h010;
        bus.i_dbus_adr = 10'h020;
        bus.i_ibus_cyc = 1'b1;
        bus.i_dbus_cyc = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (i % 3 == 2) begin
                exp_i = RrBuild && ((i / 3) % 2 == 0);
                check($sformatf("arb_xfer%0d", i / 3), {30'd0, bus.o_ibus_ack, bus.o_dbus_ack},
                      exp_i ? 32'd2 : 32'd1);
            end else begin
                check($sformatf("arb_gap%0d", i), {30'd0, bus.o_ibus_ack, bus.o_dbus_ack}, 32'd0);
            end
            tick();
        end
        bus.i_ibus_cyc = 1'b0;
        bus.i_dbus_cyc = 1'b0;

        // dbus arrives mid ibus transfer and must wait
        tick();
        bus.i_ibus_cyc = 1'b1;
        tick();
        bus.i_dbus_cyc = 1'b1;
        #1;
        check("mid_a1_dack", 32'(bus.o_dbus_ack), 32'd0);
        check("mid_a1_adr", 32'(bus.o_ram_adr), 32'h010);
        tick();
        #1;
        check("mid_a2_iack", 32'(bus.o_ibus_ack), 32'd1);
        check("mid_a2_dack", 32'(bus.o_dbus_ack), 32'd0);
        tick();
        bus.i_ibus_cyc = 1'b0;
        #1 check("mid_a3_cyc", 32'(bus.o_ram_cyc), 32'd0);
        tick();
        #1;
        check("mid_a4_cyc", 32'(bus.o_ram_cyc), 32'd1);
        check("mid_a4_adr", 32'(bus.o_ram_adr), 32'h020);
        tick();
        #1;
        check("mid_a5_dack", 32'(bus.o_dbus_ack), 32'd1);
        check("mid_a5_rdt", bus.o_dbus_rdt, 32'hAA34AA78);
        tick();
        bus.i_dbus_cyc = 1'b0;
        #1 check("mid_a6_cyc", 32'(bus.o_ram_cyc), 32'd0);

        // ibus abort after grant, then a normal dbus write
        tick();
        bus.i_ibus_cyc = 1'b1;
        tick();
        #1 check("abt_b1_cyc", 32'(bus.o_ram_cyc), 32'd1);
        tick();
        bus.i_ibus_cyc = 1'b0;
        bus.i_dbus_adr = 10'h030;
        bus.i_dbus_dat = 32'hCAFEF00D;
        bus.i_dbus_sel = 4'hF;
        bus.i_dbus_we  = 1'b1;
        bus.i_dbus_cyc = 1'b1;
        #1;
        check("abt_b2_cyc", 32'(bus.o_ram_cyc), 32'd0);
        check("abt_b2_iack", 32'(bus.o_ibus_ack), 32'd0);
        check("abt_b2_dack", 32'(bus.o_dbus_ack), 32'd0);
        tick();
        #1;
        check("abt_b3_cyc", 32'(bus.o_ram_cyc), 32'd0);
        check("abt_b3_dack", 32'(bus.o_dbus_ack), 32'd0);
        tick();
        #1;
        check("abt_b4_cyc", 32'(bus.o_ram_cyc), 32'd1);
        check("abt_b4_we", 32'(bus.o_ram_we), 32'd1);
        check("abt_b4_dat", bus.o_ram_dat, 32'hCAFEF00D);
        tick();
        #1 check("abt_b5_dack", 32'(bus.o_dbus_ack), 32'd1);
        tick();
        bus.i_dbus_cyc = 1'b0;
        bus.i_dbus_we  = 1'b0;
        #1;
        check("abt_b6_cyc", 32'(bus.o_ram_cyc), 32'd0);
        check("abt_mem", mem[10'h030], 32'hCAFEF00D);

        // Reset while dbus ack is in flight
        tick();
        bus.i_dbus_adr = 10'h020;
        bus.i_dbus_cyc = 1'b1;
        tick();
        #1 check("rmg_c1_cyc", 32'(bus.o_ram_cyc), 32'd1);
        rst = 1'b1;
        tick();
        #1;
        check("rmg_c2_cyc", 32'(bus.o_ram_cyc), 32'd0);
        check("rmg_c2_dack", 32'(bus.o_dbus_ack), 32'd0);
        check("rmg_c2_iack", 32'(bus.o_ibus_ack), 32'd0);
        rst = 1'b0;
        bus.i_ibus_adr = 10'h010;
        bus.i_ibus_cyc = 1'b1;
        tick();
        #1;
        check("rmg_c3_cyc", 32'(bus.o_ram_cyc), 32'd1);
        check("rmg_c3_adr", 32'(bus.o_ram_adr), RrBuild ? 32'h010 : 32'h020);
        tick();
        #1;
        check("rmg_c4_iack", 32'(bus.o_ibus_ack), RrBuild ? 32'd1 : 32'd0);
        check("rmg_c4_dack", 32'(bus.o_dbus_ack), RrBuild ? 32'd0 : 32'd1);
        check("rmg_c4_rdt", bus.o_ibus_rdt, RrBuild ? 32'hDEADBEEF : 32'hAA34AA78);
        tick();
        bus.i_ibus_cyc = 1'b0;
        bus.i_dbus_cyc = 1'b0;
        #1 check("rmg_c5_cyc", 32'(bus.o_ram_cyc), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
